// File: rtl/ram_pkg.sv
// Shared types and defaults for the RAM initiator: widths, FSM states and the
// registered command record.
package ram_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int LEN_WIDTH      = 2;
  localparam int COUNT_WIDTH    = 16;

  // The command record is sized for the widest instance we expect, so one
  // type serves every parameterisation; narrower instances zero-extend into it.
  localparam int CMD_ADDR_MAX = 16;
  localparam int CMD_DATA_MAX = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic                    write;
    logic [CMD_ADDR_MAX-1:0] addr;
    logic [CMD_DATA_MAX-1:0] wdata;
    logic [LEN_WIDTH-1:0]    len;
  } cmd_t;

  // A burst beat is the last one once its index reaches the stored length.
  function automatic logic beat_is_last(input logic [LEN_WIDTH-1:0] beat,
                                        input logic [LEN_WIDTH-1:0] len);
    return beat == len;
  endfunction

endpackage

// File: rtl/ram_initiator_if.sv
// Command / response handshake bundle between a client and the RAM initiator.
interface ram_initiator_if
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [LEN_WIDTH-1:0]  cmd_len;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_last;

  // The client issues commands and consumes responses.
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_len, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_last
  );

  // The initiator accepts commands and produces responses.
  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_len, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_last
  );

endinterface

// File: rtl/ram_rd_pipe.sv
// Tracks an outstanding RAM read through the fixed read latency and flags the
// cycle in which data_out holds the requested word.
module ram_rd_pipe #(
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  output logic capture
);

  logic [RD_LATENCY-1:0] valid_sr;

  // One bit per latency cycle; reset flushes any read still in flight so its
  // data is never captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_sr <= '0;
    end else begin
      valid_sr <= (valid_sr << 1) | RD_LATENCY'(issue);
    end
  end

  assign capture = valid_sr[RD_LATENCY-1];

endmodule

// File: rtl/ram_initiator.sv
// Turns single-beat write and short burst read commands into RAM strobes and
// returns read data on a valid/ready response channel.
module ram_initiator
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  ram_initiator_if.slave         bus,
  output logic                   write_enb,
  output logic                   read_enb,
  output logic [ADDR_WIDTH-1:0]  address,
  output logic [DATA_WIDTH-1:0]  data_in,
  input  logic [DATA_WIDTH-1:0]  data_out,
  output logic [COUNT_WIDTH-1:0] wr_count,
  output logic [COUNT_WIDTH-1:0] rd_count
);

  state_t                state;
  state_t                state_next;
  cmd_t                  cmd_q;
  logic [LEN_WIDTH-1:0]  beat_q;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [DATA_WIDTH-1:0] data_hold;
  logic                  capture;
  logic                  cmd_fire;
  logic                  rsp_fire;
  logic                  last_beat;
  logic                  unused_cmd;

  assign cmd_fire  = bus.cmd_valid && (state == ST_IDLE);
  assign rsp_fire  = (state == ST_RESP) && bus.rsp_ready;
  assign last_beat = beat_is_last(beat_q, cmd_q.len);

  // The opcode and the zero-extension bits of the record are carried only so
  // the whole command is latched as one unit.
  assign unused_cmd = ^{cmd_q.write, cmd_q.addr, cmd_q.wdata};

  ram_rd_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .reset   (reset),
    .issue   (read_enb),
    .capture (capture)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a stalled response parks in RESP, which also keeps any
  // new RAM access from being issued until the beat is taken.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_next = bus.cmd_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: state_next = ST_IDLE;
      ST_READ:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (capture) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_next = last_beat ? ST_IDLE : ST_READ;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake and strobe outputs decoded straight from the state, so the two
  // strobes can never overlap.
  always_comb begin
    bus.cmd_ready = (state == ST_IDLE);
    bus.rsp_valid = (state == ST_RESP);
    write_enb     = (state == ST_WRITE);
    read_enb      = (state == ST_READ);
  end

  // RAM address and write data come from the latched command while a strobe
  // is active and otherwise repeat whatever was last presented.
  always_comb begin
    address = addr_hold;
    data_in = data_hold;
    if (state == ST_WRITE) begin
      address = cmd_q.addr[ADDR_WIDTH-1:0];
      data_in = cmd_q.wdata[DATA_WIDTH-1:0];
    end else if (state == ST_READ) begin
      address = cmd_q.addr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(beat_q);
    end
  end

  // Remember the last address / write data driven so they hold between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_hold <= '0;
      data_hold <= '0;
    end else begin
      if (write_enb || read_enb) begin
        addr_hold <= address;
      end
      if (write_enb) begin
        data_hold <= data_in;
      end
    end
  end

  // Latch the command on acceptance so later changes on the bus cannot
  // disturb it, and advance the beat index on each non-final response.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q  <= '0;
      beat_q <= '0;
    end else if (cmd_fire) begin
      cmd_q.write <= bus.cmd_write;
      cmd_q.addr  <= CMD_ADDR_MAX'(bus.cmd_addr);
      cmd_q.wdata <= CMD_DATA_MAX'(bus.cmd_wdata);
      cmd_q.len   <= bus.cmd_len;
      beat_q      <= '0;
    end else if (rsp_fire && !last_beat) begin
      beat_q <= beat_q + 1'b1;
    end
  end

  // Capture the RAM word (and whether it ends the burst) on the flagged cycle;
  // both then stay put for as long as the response is back-pressured.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rsp_rdata <= '0;
      bus.rsp_last  <= 1'b0;
    end else if ((state == ST_WAIT) && capture) begin
      bus.rsp_rdata <= data_out;
      bus.rsp_last  <= last_beat;
    end
  end

  // Completed write commands and delivered read beats, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (write_enb) begin
        wr_count <= wr_count + 1'b1;
      end
      if (rsp_fire) begin
        rd_count <= rd_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/ram_initiator.md
RAM_INITIATOR -- requirements
Module: ram_initiator

Interface
REQ-001 SHALL provide parameters: DATA_WIDTH, default 8, RAM word width; ADDR_WIDTH, default 4, RAM address width (16 words); RD_LATENCY, default 1, cycles from RAM sampling read_enb to data_out valid (legal 1..4).
REQ-002 SHALL be a single clock domain; reset synchronous, active-high.
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  ADDR_WIDTH  start address.
REQ-009 cmd_wdata  input  DATA_WIDTH  write data (writes are single-beat).
REQ-010 cmd_len  input  2  read burst length minus 1 (1..4 beats); ignored for writes.
REQ-011 rsp_valid  output  1  read data beat available.
REQ-012 rsp_ready  input  1  consumer accepts beat.
REQ-013 rsp_rdata  output  DATA_WIDTH  read data.
REQ-014 rsp_last  output  1  final beat of burst.
REQ-015 write_enb, read_enb  output  1 each  RAM strobes.
REQ-016 address  output  ADDR_WIDTH  RAM address.
REQ-017 data_in  output  DATA_WIDTH  RAM write data.
REQ-018 data_out  input  DATA_WIDTH  RAM read data.
REQ-019 wr_count, rd_count  output  16 each  completed write commands / read beats, wrap at 2^16.

Function
REQ-020 FSM states IDLE, WRITE, READ, WAIT, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-021 IDLE + accepted write -> WRITE: next cycle write_enb=1, address=cmd_addr, data_in=cmd_wdata for exactly one cycle; wr_count+1; -> IDLE.
REQ-022 IDLE + accepted read -> READ: next cycle read_enb=1 for exactly one cycle with current beat address; -> WAIT.
REQ-023 WAIT SHALL last RD_LATENCY cycles; data_out captured into rsp_rdata at end of last WAIT cycle; -> RESP (RD_LATENCY=1: read_enb in cycle T, rsp_valid first high in T+2).
REQ-024 RESP: rsp_valid=1, rsp_rdata and rsp_last stable until rsp_valid && rsp_ready; on handshake rd_count+1; if last beat -> IDLE else address+1 -> READ.
REQ-025 Burst address SHALL wrap modulo 2^ADDR_WIDTH (15 -> 0).
REQ-026 write_enb and read_enb SHALL never be high in the same cycle; both 0 outside WRITE/READ; address and data_in hold last value when strobes low.
REQ-027 No new RAM access SHALL be issued while rsp_valid is held under back-pressure.
REQ-028 cmd_* inputs SHALL be registered at acceptance; later changes have no effect on an active command.

Reset
REQ-029 With reset high at a rising edge: state=IDLE, cmd_ready=1 from next cycle, rsp_valid=0, rsp_last=0, rsp_rdata=0, write_enb=0, read_enb=0, address=0, data_in=0, wr_count=0, rd_count=0.
REQ-030 Reset mid-burst or mid-WAIT SHALL abandon the command; in-flight data_out discarded, no response produced.

Structure
REQ-031 Shared package ram_pkg SHALL hold DATA_WIDTH/ADDR_WIDTH defaults, the FSM state enum and a packed command struct (write, addr, wdata, len).
REQ-032 Sub-module ram_rd_pipe SHALL implement the RD_LATENCY valid shift register that flags the capture cycle.

Verification
REQ-033 Write addr 3 data 0xA5, then read addr 3 len 0 -> one write_enb pulse at 3/0xA5; rsp_rdata=0xA5, rsp_last=1, rsp_valid 2 cycles after read_enb; wr_count=1, rd_count=1.
REQ-034 Preload 14,15,0,1 with 0x11,0x22,0x33,0x44; read addr 14 len 3 -> read_enb addresses 14,15,0,1; beats 0x11..0x44; rsp_last only on 0x44.
REQ-035 Read with rsp_ready low 3 cycles -> rsp_valid held, rsp_rdata stable, no read_enb until handshake.
REQ-036 cmd_valid held high during burst -> cmd_ready=0 until IDLE; second command accepted exactly one cycle after final rsp handshake.
REQ-037 Reset asserted in WAIT of 4-beat burst -> next cycle all outputs at reset values, no rsp_valid, counters 0.
REQ-038 RD_LATENCY=3 build, read addr 5 -> rsp_valid 4 cycles after read_enb, correct data.
